// File: rtl/rtc_bus_responder_if.sv
// Multiplexed address/data bus between an RTC controller and the RTC chip.
// The master owns the strobes and ad_in; the responder owns ad_out/ad_oe.
interface rtc_bus_responder_if;
    logic       a_d;
    logic       cs;
    logic       rd;
    logic       wr;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;

    modport master (
        output a_d, cs, rd, wr, ad_in,
        input  ad_out, ad_oe
    );

    modport slave (
        input  a_d, cs, rd, wr, ad_in,
        output ad_out, ad_oe
    );
endinterface

// File: rtl/rtc_bus_responder.sv
// On-FPGA stand-in for the RTC chip: decodes the a_d/cs/rd/wr bus, serves
// a 256x8 register file and keeps BCD seconds/minutes/hours running.
module rtc_bus_responder #(
    parameter logic [7:0] ADDR_SEG  = 8'h21,
    parameter logic [7:0] ADDR_MIN  = 8'h22,
    parameter logic [7:0] ADDR_HORA = 8'h23,
    parameter logic [7:0] ADDR_CMD  = 8'hF0
) (
    input  logic               clk,
    input  logic               reset,
    rtc_bus_responder_if.slave bus,
    input  logic               tick_1hz,
    output logic               bus_err,
    output logic [7:0]         addr_q
);

    typedef enum logic [1:0] {IDLE, ADDR, WDAT, RDAT} state_t;

    state_t     state;
    state_t     state_n;
    logic       rd_q;
    logic       wr_q;
    logic       err_lock;
    logic       tick_pend;
    logic [7:0] ad_q;
    logic [7:0] regs [256];

    logic       conflict;
    logic       wr_rise;
    logic       rd_rise;
    logic       latch;
    logic       commit;
    logic       load;
    logic       tick_do;
    logic       seg_c;
    logic       min_c;
    logic [7:0] seg_n;
    logic [7:0] min_n;
    logic [7:0] hora_n;

    // Out-of-range values wrap to 00 on the next increment.
    function automatic logic [7:0] bcd_inc(
        input logic [7:0] v,
        input logic [7:0] lim
    );
        if (v >= lim)
            return 8'h00;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'h0};
        else
            return v + 8'd1;
    endfunction

    assign conflict = !bus.cs && !bus.rd && !bus.wr;
    assign wr_rise  = !wr_q && bus.wr;
    assign rd_rise  = !rd_q && bus.rd;
    assign tick_do  = (tick_1hz || tick_pend) && !commit;
    assign seg_c    = regs[ADDR_SEG] >= 8'h59;
    assign min_c    = regs[ADDR_MIN] >= 8'h59;
    assign seg_n    = bcd_inc(regs[ADDR_SEG], 8'h59);
    assign min_n    = bcd_inc(regs[ADDR_MIN], 8'h59);
    assign hora_n   = bcd_inc(regs[ADDR_HORA], 8'h23);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        latch   = 1'b0;
        commit  = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!bus.cs && !conflict && !err_lock) begin
                    if (!bus.a_d && !bus.wr) begin
                        state_n = ADDR;
                    end else if (bus.a_d && !bus.wr) begin
                        state_n = WDAT;
                    end else if (bus.a_d && !bus.rd) begin
                        state_n = RDAT;
                        load    = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (bus.cs || conflict || bus.a_d) begin
                    state_n = IDLE;
                end else if (wr_rise) begin
                    state_n = IDLE;
                    latch   = 1'b1;
                end
            end
            WDAT: begin
                if (bus.cs || conflict || !bus.a_d) begin
                    state_n = IDLE;
                end else if (wr_rise) begin
                    state_n = IDLE;
                    commit  = addr_q != ADDR_CMD;
                end
            end
            RDAT: begin
                if (bus.cs || conflict || !bus.a_d || rd_rise)
                    state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q       <= 1'b1;
            wr_q       <= 1'b1;
            ad_q       <= 8'h00;
            err_lock   <= 1'b0;
            bus_err    <= 1'b0;
            addr_q     <= 8'h00;
            bus.ad_out <= 8'h00;
            bus.ad_oe  <= 1'b0;
            tick_pend  <= 1'b0;
        end else begin
            rd_q    <= bus.rd;
            wr_q    <= bus.wr;
            ad_q    <= bus.ad_in;
            bus_err <= conflict;
            if (conflict)
                err_lock <= 1'b1;
            else if (bus.rd && bus.wr)
                err_lock <= 1'b0;
            if (latch)
                addr_q <= bus.ad_in;
            if (load)
                bus.ad_out <= (addr_q == ADDR_CMD) ? 8'h00 : regs[addr_q];
            bus.ad_oe <= state_n == RDAT;
            // A tick colliding with a commit is deferred by one cycle.
            if (commit)
                tick_pend <= tick_pend || tick_1hz;
            else
                tick_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 256; i++)
                regs[i] <= 8'h00;
        end else if (commit) begin
            regs[addr_q] <= ad_q;
        end else if (tick_do) begin
            regs[ADDR_SEG] <= seg_n;
            if (seg_c)
                regs[ADDR_MIN] <= min_n;
            if (seg_c && min_c)
                regs[ADDR_HORA] <= hora_n;
        end
    end

endmodule
